// File: rtl/cgr_pkg.sv
// cgr_pkg: symbol encodings, sequencer states and memory depth helper for the CGR k-mer counter
package cgr_pkg;
  localparam logic [1:0] SYM_A = 2'd0;
  localparam logic [1:0] SYM_C = 2'd1;
  localparam logic [1:0] SYM_G = 2'd2;
  localparam logic [1:0] SYM_T = 2'd3;
  typedef enum logic [2:0] {IDLE, CLEAR, COUNT_RD, COUNT_WR, DUMP_RD, DUMP_WAIT, DUMP_OUT, DONE} state_e;
  function automatic int depth(input int k);
    return 1 << (2 * k);
  endfunction
endpackage

// File: rtl/cgr_count_if.sv
// cgr_count_if: control, symbol stream, count RAM and dump stream of the k-mer counter
// master = sequencer (owns the RAM and the dump stream), slave = symbol source / RAM / dump sink
interface cgr_count_if #(parameter int K = 3, parameter int CNT_W = 16, parameter int LEN_W = 16);
  logic             start;
  logic [LEN_W-1:0] seq_len;
  logic             sym_valid;
  logic [1:0]       sym;
  logic             sym_ready;
  logic [2*K-1:0]   mem_addr;
  logic             mem_ren;
  logic [CNT_W-1:0] mem_rdata;
  logic             mem_wen;
  logic [CNT_W-1:0] mem_wdata;
  logic             out_valid;
  logic             out_ready;
  logic [2*K-1:0]   out_addr;
  logic [CNT_W-1:0] out_data;
  logic             busy;
  logic             done;
  modport master (
    input  start, seq_len, sym_valid, sym, mem_rdata, out_ready,
    output sym_ready, mem_addr, mem_ren, mem_wen, mem_wdata, out_valid, out_addr, out_data, busy, done
  );
  modport slave (
    output start, seq_len, sym_valid, sym, mem_rdata, out_ready,
    input  sym_ready, mem_addr, mem_ren, mem_wen, mem_wdata, out_valid, out_addr, out_data, busy, done
  );
endinterface

// File: rtl/cgr_addr_shift.sv
// cgr_addr_shift: enable-driven CGR x/y shift registers, newest symbol enters at the MSB
// ports: clk, rst_n, en_i (shift), sym_i (bit1->x, bit0->y), addr_o = {x,y}, addr_nxt_o = {x,y} after this cycle's shift
module cgr_addr_shift #(parameter int K = 3) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en_i,
  input  logic [1:0]     sym_i,
  output logic [2*K-1:0] addr_o,
  output logic [2*K-1:0] addr_nxt_o
);
  logic [K-1:0] x_q, y_q, x_d, y_d;
  assign x_d = en_i ? {sym_i[1], x_q[K-1:1]} : x_q;
  assign y_d = en_i ? {sym_i[0], y_q[K-1:1]} : y_q;
  assign addr_o = {x_q, y_q};
  assign addr_nxt_o = {x_d, y_d};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
endmodule

// File: rtl/cgr_count_ctrl.sv
// cgr_count_ctrl: clears the 4^K count RAM, counts k-mers by read-modify-write, then dumps all counts in address order
// ports: clk, rst_n (async, active low), bus (cgr_count_if.master: start/seq_len, symbol stream, RAM port, dump stream, busy/done)
module cgr_count_ctrl
  import cgr_pkg::*;
#(parameter int K = 3, parameter int CNT_W = 16, parameter int LEN_W = 16) (
  input logic        clk,
  input logic        rst_n,
  cgr_count_if.master bus
);
  localparam logic [2*K:0] LAST = (2*K+1)'(depth(K) - 1);
  state_e           state_q;
  logic [LEN_W-1:0] seq_len_q, sym_cnt_q, sym_cnt_d;
  logic [2*K:0]     addr_cnt_q;
  logic [2*K-1:0]   out_addr_q, kmer_addr, kmer_addr_nxt;
  logic [CNT_W-1:0] out_data_q, inc_data;
  logic             out_valid_q, busy_q, done_q, acc, counted;
  assign acc = (state_q == COUNT_RD) && bus.sym_valid;
  assign sym_cnt_d = sym_cnt_q + 1'b1;
  assign counted = acc && (sym_cnt_d >= LEN_W'(K));
  assign inc_data = &bus.mem_rdata ? bus.mem_rdata : bus.mem_rdata + 1'b1;
  cgr_addr_shift #(.K(K)) u_shift (
    .clk(clk), .rst_n(rst_n), .en_i(acc), .sym_i(bus.sym),
    .addr_o(kmer_addr), .addr_nxt_o(kmer_addr_nxt)
  );
  assign bus.sym_ready = state_q == COUNT_RD;
  // the read for a counted k-mer issues in the accept cycle, so it must use the post-shift address
  assign bus.mem_addr = state_q == COUNT_RD ? kmer_addr_nxt : state_q == COUNT_WR ? kmer_addr : addr_cnt_q[2*K-1:0];
  assign bus.mem_ren = counted || state_q == DUMP_RD;
  assign bus.mem_wen = state_q == CLEAR || state_q == COUNT_WR;
  assign bus.mem_wdata = state_q == COUNT_WR ? inc_data : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr = out_addr_q;
  assign bus.out_data = out_data_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      seq_len_q <= '0;
      sym_cnt_q <= '0;
      addr_cnt_q <= '0;
      out_addr_q <= '0;
      out_data_q <= '0;
      out_valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          seq_len_q <= bus.seq_len;
          sym_cnt_q <= '0;
          addr_cnt_q <= '0;
          busy_q <= 1'b1;
          state_q <= CLEAR;
        end
        CLEAR: if (addr_cnt_q == LAST) begin
          addr_cnt_q <= '0;
          state_q <= seq_len_q == '0 ? DUMP_RD : COUNT_RD;
        end else addr_cnt_q <= addr_cnt_q + 1'b1;
        COUNT_RD: if (acc) begin
          sym_cnt_q <= sym_cnt_d;
          state_q <= counted ? COUNT_WR : sym_cnt_d == seq_len_q ? DUMP_RD : COUNT_RD;
        end
        COUNT_WR: state_q <= sym_cnt_q == seq_len_q ? DUMP_RD : COUNT_RD;
        DUMP_RD: state_q <= DUMP_WAIT;
        DUMP_WAIT: begin
          out_data_q <= bus.mem_rdata;
          out_addr_q <= addr_cnt_q[2*K-1:0];
          out_valid_q <= 1'b1;
          state_q <= DUMP_OUT;
        end
        // valid drops on every handshake so stale data is never re-offered while the next word is read
        DUMP_OUT: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          if (addr_cnt_q == LAST) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state_q <= DONE;
          end else begin
            addr_cnt_q <= addr_cnt_q + 1'b1;
            state_q <= DUMP_RD;
          end
        end
        DONE: state_q <= IDLE;
      endcase
    end
endmodule
